instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a load session; honoured only in IDLE, DONE and ERR.
REQ-005 SHALL have port byte_in  input  8  incoming program-stream byte.
REQ-006 SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port imem_wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  ADDR_W  word address for the write.
REQ-010 SHALL have port imem_wr_data  output  32  instruction word for the write.
REQ-011 SHALL have port cpu_hold  output  1  high = CPU instruction fetch stalled.
REQ-012 SHALL have port done  output  1  load completed with a good checksum.
REQ-013 SHALL have port error  output  1  load aborted: bad length or bad checksum.

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both high; the loader SHALL sustain one byte per cycle.
REQ-015 SHALL accept this stream format: LEN_HI, LEN_LO (16-bit word count N, MSB first), 4*N data bytes (each word MSB first), then one checksum byte.
REQ-016 SHALL define the checksum as the XOR of every byte before it, including the two length bytes.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE and ERR.
REQ-018 SHALL drive byte_ready high only in LEN_HI, LEN_LO, DATA and CHECK, with no stall during a write strobe.
REQ-019 SHALL move IDLE, DONE or ERR to LEN_HI on start=1; this transition clears done, error, the word index and the running XOR, and sets cpu_hold=1.
REQ-020 SHALL move LEN_HI to LEN_LO on acceptance of a byte.
REQ-021 SHALL, on byte acceptance in LEN_LO, go to ERR if N > 2^ADDR_W, to CHECK if N = 0, and to DATA otherwise.
REQ-022 SHALL use a 2-bit byte counter in DATA that shifts bytes into a 32-bit assembly register.
REQ-023 SHALL, on the edge accepting the 4th byte of a word, register imem_wr_en=1, imem_addr=word index and imem_wr_data=assembled word, so the strobe is high exactly one cycle later.
REQ-024 SHALL increment the word index after each write and SHALL move to CHECK once word N-1's 4th byte is accepted.
REQ-025 SHALL hold imem_wr_en at 0 in every cycle other than the one-cycle strobe in REQ-023.
REQ-026 SHALL hold imem_addr and imem_wr_data at their last values when no strobe is active.
REQ-027 SHALL, in CHECK, compare the accepted byte with the running XOR: on a match go to DONE, on a mismatch go to ERR.
REQ-028 SHALL, in DONE, hold done=1 and cpu_hold=0.
REQ-029 SHALL, in ERR, hold error=1 and cpu_hold=1; words already written are not retracted.
REQ-030 SHALL hold cpu_hold=1 in every state except DONE.
REQ-031 SHALL ignore start in LEN_HI, LEN_LO, DATA and CHECK.
REQ-032 SHALL ignore byte_valid whenever byte_ready=0.

Reset
REQ-033 SHALL, on reset=1 at a rising edge, go to IDLE with byte_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, cpu_hold=1, done=0, error=0, and all counters and the XOR cleared.
REQ-034 SHALL let reset override start and byte acceptance on the same edge.
REQ-035 SHALL, on reset mid-session, discard any partially assembled word with no write, while memory already written stays as is.

Verification
REQ-036 SHALL cover: ADDR_W=8, start, then bytes 00 02 3C 01 00 05 00 22 18 20 20 -> writes addr0=0x3C010005 and addr1=0x00221820, then done=1 and cpu_hold=0.
REQ-037 SHALL cover: the same stream with checksum 0x21 -> both writes occur, then error=1, done=0, cpu_hold=1.
REQ-038 SHALL cover: bytes 00 00 00 -> no imem_wr_en, then done=1.
REQ-039 SHALL cover: bytes 01 01 (N=257) -> ERR right after LEN_LO, byte_ready=0, no writes.
REQ-040 SHALL cover: reset after 2 data bytes of word 0 -> IDLE, no write; a following start plus the REQ-036 stream still gives the same results.
REQ-041 SHALL cover: the REQ-036 stream with random byte_valid gaps, and start pulsed during DATA -> identical writes and done; start has no effect.

Source files
------------

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Receives a byte-serial program image and writes it into instruction memory
// one 32-bit word at a time. While a load is in progress, the CPU is held off.
//
// Stream format:
//   LEN_HI, LEN_LO  16-bit word count N, MSB first
//   4*N data bytes  each word MSB first
//   checksum        XOR of every preceding byte, including the length bytes
//
// Parameters:
//   ADDR_W        instruction-memory word-address width (2^ADDR_W words)
//
// Ports:
//   clock         system clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   start         begin a load session (honoured only in idle/done/error)
//   byte_in       incoming stream byte
//   byte_valid    byte_in is valid this cycle
//   byte_ready    loader accepts a byte this cycle
//   imem_wr_en    one-cycle instruction-memory write strobe
//   imem_addr     word address for the write (holds between strobes)
//   imem_wr_data  instruction word for the write (holds between strobes)
//   cpu_hold      high = CPU instruction fetch stalled
//   done          load completed with a good checksum
//   error         load aborted: bad length or bad checksum
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StErr
    } state_e;

    // Largest word count that still fits in memory.
    localparam longint unsigned Capacity = longint'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Only the first three bytes of a word need storing; the fourth comes
    // straight from byte_in on the edge that writes the word.
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [31:0]       wr_data_d;

    logic              accept;
    logic [15:0]       len_n;

    assign accept = byte_valid & byte_ready;
    assign len_n  = {len_hi_q, byte_in};

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        words_left_d = words_left_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = imem_addr;
        wr_data_d    = imem_wr_data;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d      = StLenHi;
                    words_left_d = '0;
                    word_idx_d   = '0;
                    byte_cnt_d   = '0;
                    asm_d        = '0;
                    xor_d        = '0;
                end
            end

            StLenHi: begin
                if (accept) begin
                    len_hi_d = byte_in;
                    xor_d    = xor_q ^ byte_in;
                    state_d  = StLenLo;
                end
            end

            StLenLo: begin
                if (accept) begin
                    xor_d        = xor_q ^ byte_in;
                    words_left_d = len_n;
                    if (longint'(len_n) > Capacity) begin
                        state_d = StErr;
                    end else if (len_n == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    xor_d      = xor_q ^ byte_in;
                    asm_d      = {asm_q[15:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = word_idx_q;
                        wr_data_d    = {asm_q, byte_in};
                        word_idx_d   = word_idx_q + 1'b1;
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) begin
                            state_d = StCheck;
                        end
                    end
                end
            end

            StCheck: begin
                if (accept) begin
                    state_d = (byte_in == xor_q) ? StDone : StErr;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs. Status outputs are decoded from the
    // next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            len_hi_q     <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_wr_data <= '0;
            byte_ready   <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            words_left_q <= words_left_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            imem_wr_en   <= wr_en_d;
            imem_addr    <= wr_addr_d;
            imem_wr_data <= wr_data_d;
            byte_ready   <= (state_d == StLenHi) || (state_d == StLenLo) ||
                            (state_d == StData)  || (state_d == StCheck);
            cpu_hold     <= (state_d != StDone);
            done         <= (state_d == StDone);
            error        <= (state_d == StErr);
        end
    end

endmodule
